// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

    localparam int unsigned DefDw = 32;
    localparam int unsigned DefVw = 32;
    localparam int unsigned DefQw = 14;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StCalc = 2'd1;
    localparam state_t StDone = 2'd2;

    // Width of a counter that must hold 0 .. value-1; never narrower than 1 bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/seq_div_unit_if.sv
// Request/result bundle between a divider client (master) and seq_div_unit (slave).
interface seq_div_unit_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned VW = 32,
    parameter int unsigned QW = 14
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [QW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic          overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract, shift in the quotient bit.
module seq_div_step #(
    parameter int unsigned DW = 32,
    parameter int unsigned VW = 32
) (
    input  logic [VW-1:0] rem_i,
    input  logic [DW-1:0] quo_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW-1:0] rem_o,
    output logic [DW-1:0] quo_o
);
    logic [VW:0] shifted;
    logic [VW:0] diff;
    logic        take;

    always_comb begin
        shifted = {rem_i, quo_i[DW-1]};
        diff    = shifted - {1'b0, divisor_i};
        take    = (shifted >= {1'b0, divisor_i});
        rem_o   = take ? diff[VW-1:0] : shifted[VW-1:0];
        quo_o   = {quo_i[DW-2:0], take};
    end
endmodule

// File: rtl/seq_div_unit.sv
// Multi-cycle restoring divider with start/busy/done handshake and saturating quotient.
// Two's-complement operands are supported when SEQ_DIV_SIGNED_EN is defined.
module seq_div_unit
    import seq_div_pkg::*;
#(
    parameter int unsigned DW = DefDw,
    parameter int unsigned VW = DefVw,
    parameter int unsigned QW = DefQw
) (
    input  logic           clk,
    input  logic           rstn,
    seq_div_unit_if.slave  div_io
);
    localparam int unsigned CW = clog2(DW);

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [VW-1:0] rem_q, rem_d;
    logic [VW-1:0] dvs_q, dvs_d;
    // Holds the dividend on capture and fills with quotient bits as CALC shifts.
    logic [DW-1:0] quo_q, quo_d;

    logic          done_q, done_d;
    logic [QW-1:0] qout_q, qout_d;
    logic [VW-1:0] rout_q, rout_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [VW-1:0] step_rem;
    logic [DW-1:0] step_quo;
    logic [DW-1:0] cap_dvd;
    logic [VW-1:0] cap_dvs;
    logic          div_zero;
    logic [QW-1:0] res_quo;
    logic [VW-1:0] res_rem;
    logic          res_ovf;

    seq_div_step #(
        .DW(DW),
        .VW(VW)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign div_zero = (dvs_q == '0);

`ifdef SEQ_DIV_SIGNED_EN
    localparam logic [QW-1:0] QPosMax = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] QNegMin = {1'b1, {(QW-1){1'b0}}};

    logic          sgn_dvd_q, sgn_dvs_q;
    logic          neg_quo;
    logic          q_big;
    logic          q_min;
    logic [VW-1:0] rem_mag;

    // The most negative operand negates to itself, which is already its unsigned magnitude.
    assign cap_dvd = div_io.dividend[DW-1] ? -div_io.dividend : div_io.dividend;
    assign cap_dvs = div_io.divisor[VW-1]  ? -div_io.divisor  : div_io.divisor;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sgn_dvd_q <= 1'b0;
            sgn_dvs_q <= 1'b0;
        end else if (state_q == StIdle && div_io.start) begin
            sgn_dvd_q <= div_io.dividend[DW-1];
            sgn_dvs_q <= div_io.divisor[VW-1];
        end
    end

    always_comb begin
        neg_quo = sgn_dvd_q ^ sgn_dvs_q;
        rem_mag = div_zero ? quo_q[VW-1:0] : rem_q;
        res_rem = sgn_dvd_q ? -rem_mag : rem_mag;
        q_big   = |quo_q[DW-1:QW-1];
        q_min   = (quo_q == (DW'(1) << (QW-1)));
        res_ovf = 1'b0;
        if (div_zero) begin
            res_quo = sgn_dvd_q ? QNegMin : QPosMax;
        end else if (q_big && !(neg_quo && q_min)) begin
            res_ovf = 1'b1;
            res_quo = neg_quo ? QNegMin : QPosMax;
        end else begin
            res_quo = neg_quo ? -quo_q[QW-1:0] : quo_q[QW-1:0];
        end
    end
`else
    assign cap_dvd = div_io.dividend;
    assign cap_dvs = div_io.divisor;

    always_comb begin
        res_ovf = !div_zero && (|quo_q[DW-1:QW]);
        res_rem = div_zero ? quo_q[VW-1:0] : rem_q;
        res_quo = (div_zero || res_ovf) ? '1 : quo_q[QW-1:0];
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        done_d  = 1'b0;
        qout_d  = qout_q;
        rout_d  = rout_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (div_io.start) begin
                    quo_d   = cap_dvd;
                    dvs_d   = cap_dvs;
                    rem_d   = '0;
                    count_d = '0;
                    state_d = (cap_dvs == '0) ? StDone : StCalc;
                end
            end
            StCalc: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + 1'b1;
                if (count_q == CW'(DW - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                qout_d  = res_quo;
                rout_d  = res_rem;
                dbz_d   = div_zero;
                ovf_d   = res_ovf;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            count_q <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            done_q  <= 1'b0;
            qout_q  <= '0;
            rout_q  <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            done_q  <= done_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    // done is registered, so busy must also cover the cycle in which done is high.
    assign div_io.busy        = (state_q != StIdle) || done_q;
    assign div_io.done        = done_q;
    assign div_io.quotient    = qout_q;
    assign div_io.remainder   = rout_q;
    assign div_io.div_by_zero = dbz_q;
    assign div_io.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_div_unit.sv
// Self-checking bench for seq_div_unit: timeline/arithmetic reference model plus directed cases.
module tb_seq_div_unit;
    localparam int unsigned DW = 32;
    localparam int unsigned VW = 32;
    localparam int unsigned QW = 14;

    typedef struct packed {
        logic [QW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
        logic          ovf;
    } res_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    seq_div_unit_if #(.DW(DW), .VW(VW), .QW(QW)) dif ();

    seq_div_unit #(
        .DW(DW),
        .VW(VW),
        .QW(QW)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .div_io (dif)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: what one operation must return.
`ifdef SEQ_DIV_SIGNED_EN
    function automatic res_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
        res_t   res;
        longint sa, sb, qt, rt, qmax, qmin;
        res  = '0;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        qmax = (longint'(1) << (QW - 1)) - 1;
        qmin = -(longint'(1) << (QW - 1));
        if (sb == 0) begin
            res.dbz = 1'b1;
            res.r   = a[VW-1:0];
            qt      = (sa < 0) ? qmin : qmax;
        end else begin
            qt    = sa / sb;
            rt    = sa % sb;
            res.r = rt[VW-1:0];
            if (qt > qmax) begin
                qt      = qmax;
                res.ovf = 1'b1;
            end else if (qt < qmin) begin
                qt      = qmin;
                res.ovf = 1'b1;
            end
        end
        res.q = qt[QW-1:0];
        return res;
    endfunction
`else
    function automatic res_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
        res_t        res;
        logic [63:0] qt;
        res = '0;
        if (b == '0) begin
            res.dbz = 1'b1;
            res.q   = '1;
            res.r   = a[VW-1:0];
        end else begin
            qt    = {32'd0, a} / {32'd0, b};
            res.r = VW'({32'd0, a} % {32'd0, b});
            if (qt >= (64'd1 << QW)) begin
                res.q   = '1;
                res.ovf = 1'b1;
            end else begin
                res.q = qt[QW-1:0];
            end
        end
        return res;
    endfunction
`endif

    // Timeline model: edge index of acceptance and of the done cycle.
    longint cyc       = 0;
    longint m_done_at = -10;
    logic   m_active  = 1'b0;
    res_t   m_pend    = '0;
    res_t   m_res     = '0;

    always begin : model_p
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            m_active  = 1'b0;
            m_done_at = -10;
            m_res     = '0;
        end else begin
            cyc++;
            if (dif.start && (!m_active || cyc - 1 == m_done_at)) begin
                m_active  = 1'b1;
                m_done_at = cyc + ((dif.divisor == '0) ? 1 : DW + 1);
                m_pend    = model(dif.dividend, dif.divisor);
            end else if (m_active && cyc - 1 == m_done_at) begin
                m_active = 1'b0;
            end
            if (m_active && cyc == m_done_at) begin
                m_res = m_pend;
            end
        end
    end

    always begin : cmp_p
        logic [QW+VW+3:0] exp_v, act_v;
        @(negedge clk);
        #1;
        exp_v = {m_active, m_active && (cyc == m_done_at), m_res};
        act_v = {dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero, dif.overflow};
        compared++;
        if (act_v !== exp_v) begin
            mismatched++;
            $display("FAIL cycle %0d: busy,done,q,r,dbz,ovf got %b,%b,%h,%h,%b,%b want %b,%b,%h,%h,%b,%b",
                     cyc, dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero,
                     dif.overflow, exp_v[QW+VW+3], exp_v[QW+VW+2], m_res.q, m_res.r, m_res.dbz,
                     m_res.ovf);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] v;
        case ($urandom % 4)
            0:       v = 32'd0;
            1:       v = $urandom % 16;
            2:       v = $urandom;
            default: v = $urandom >> ($urandom % 32);
        endcase
        return v;
    endfunction

    // Call at a negedge with the DUT able to accept; returns at the negedge of cycle 0.
    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        @(negedge clk);
        dif.start    = 1'b0;
        dif.dividend = $urandom;
        dif.divisor  = $urandom;
    endtask

    task automatic await_done(input string name, input int lat, input logic [QW-1:0] eq,
                              input logic [VW-1:0] er, input logic edbz, input logic eovf);
        int n;
        n = 0;
        while (!dif.done && n < lat + 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 64'(n), 64'(lat));
        check({name, " quotient"}, 64'(dif.quotient), 64'(eq));
        check({name, " remainder"}, 64'(dif.remainder), 64'(er));
        check({name, " flags"}, {62'd0, dif.div_by_zero, dif.overflow}, {62'd0, edbz, eovf});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {dif.busy, dif.done, dif.quotient, dif.remainder,
              dif.div_by_zero, dif.overflow}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        issue(32'd100, 32'd7);
        await_done("100/7", DW + 1, 14'd14, 32'd2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
`ifdef SEQ_DIV_SIGNED_EN
        issue(32'd12345, 32'd0);
        await_done("12345/0", 1, 14'h1FFF, 32'd12345, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        issue(-32'sd7, 32'd2);
        await_done("-7/2", DW + 1, 14'h3FFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        issue(32'd7, -32'sd2);
        await_done("7/-2", DW + 1, 14'h3FFD, 32'd1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        issue(32'h8000_0000, 32'd1);
        await_done("-2^31/1", DW + 1, 14'h2000, 32'd0, 1'b0, 1'b1);
`else
        issue(32'hFFFF_FFFF, 32'd1);
        await_done("ffffffff/1", DW + 1, 14'h3FFF, 32'd0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        issue(32'd12345, 32'd0);
        await_done("12345/0", 1, 14'h3FFF, 32'd12345, 1'b1, 1'b0);
`endif
        repeat (2) @(negedge clk);

        // Start pulse while busy must be dropped.
        issue(32'd50, 32'd5);
        repeat (9) @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 32'd9;
        dif.divisor  = 32'd3;
        @(negedge clk);
        dif.start = 1'b0;
        await_done("50/5", DW + 1 - 10, 14'd10, 32'd0, 1'b0, 1'b0);
        issue(32'd9, 32'd3);
        await_done("9/3 back-to-back", DW + 1, 14'd3, 32'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        issue(32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("async reset outputs", {dif.busy, dif.done, dif.quotient, dif.remainder,
              dif.div_by_zero, dif.overflow}, 64'd0);
        repeat (DW + 4) @(negedge clk);
        check("no done under reset", {63'd0, dif.done}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        issue(32'd1000, 32'd3);
        await_done("1000/3 after reset", DW + 1, 14'd333, 32'd1, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            dif.start    = (($urandom % 3) == 0);
            dif.dividend = rnd_val();
            dif.divisor  = rnd_val();
            @(negedge clk);
        end
        dif.start = 1'b0;
        repeat (DW + 4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
